// File: rtl/neopixel_frame_ctl.sv
// neopixel_frame_ctl: pixel buffer plus frame serialiser for a WS2812 bit encoder.
// Pixels are written bytewise into a simple dual-port RAM. A frame is shifted out
// MSB first over a bit_rdy/bit_done handshake, followed by a RESET_CYCLES latch code.
// Optional build macro: NEOPIXEL_BRIGHTNESS_EN enables the per-lane global brightness
// scaler applied to each fetched word.
module neopixel_frame_ctl #(
  parameter int unsigned PIXEL_BITS   = 24,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned RESET_CYCLES = 10000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    wr_en_in,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_in,
  input  logic [PIXEL_BITS/8-1:0] byte_en_in,
  input  logic [7:0]              byte_data_in,
  input  logic                    frame_rdy_in,
  input  logic [ADDR_WIDTH:0]     frame_len_in,
  input  logic [7:0]              brightness_in,
  input  logic                    bit_done_in,
  output logic                    bit_rdy_out,
  output logic                    bit_data_out,
  output logic                    busy_out,
  output logic                    frame_done_out
);

  localparam int unsigned LANES = PIXEL_BITS / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned BW    = $clog2(PIXEL_BITS);
  localparam int unsigned CW    = $clog2(RESET_CYCLES + 1);

  localparam logic [BW-1:0]       LAST_BIT = BW'(PIXEL_BITS - 1);
  localparam logic [CW-1:0]       LAST_CNT = CW'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] MAX_LEN  = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_RST    = 3'd5;

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH:0]   len_q,      len_d;
  logic [ADDR_WIDTH:0]   pix_q,      pix_d;
  logic [BW-1:0]         bit_idx_q,  bit_idx_d;
  logic [CW-1:0]         cnt_q,      cnt_d;
  logic [PIXEL_BITS-1:0] shift_q,    shift_d;
  logic                  bit_rdy_q,  bit_rdy_d;
  logic                  bit_data_q, bit_data_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic                  rd_en;
  logic [PIXEL_BITS-1:0] rd_data;
  logic [PIXEL_BITS-1:0] load_word;

`ifdef NEOPIXEL_BRIGHTNESS_EN
  logic [7:0] bri_q, bri_d;
  logic [8:0] scale;
  assign scale = {1'b0, bri_q} + 9'd1;
`else
  logic unused_bri;
  assign unused_bri = ^brightness_in;
`endif

  // Pixel RAM split into byte lanes so each lane is a plain 8-bit memory with its own write enable
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte_q;

    // Lane write plus registered read; same-address collisions return the old byte
    always_ff @(posedge clk_in) begin
      if (wr_en_in && byte_en_in[g]) begin
        mem[wr_addr_in] <= byte_data_in;
      end
      if (rd_en) begin
        rd_byte_q <= mem[pix_q[ADDR_WIDTH-1:0]];
      end
    end

    assign rd_data[g*8 +: 8] = rd_byte_q;

`ifdef NEOPIXEL_BRIGHTNESS_EN
    assign load_word[g*8 +: 8] = 8'((16'(rd_byte_q) * 16'(scale)) >> 8);
`else
    assign load_word[g*8 +: 8] = rd_byte_q;
`endif
  end

  // Frame sequencing: accept, fetch/load each pixel, shift its bits out, then hold the latch code
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pix_d      = pix_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bit_rdy_d  = 1'b0;
    bit_data_d = bit_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en      = 1'b0;
`ifdef NEOPIXEL_BRIGHTNESS_EN
    bri_d      = bri_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (frame_rdy_in) begin
          state_d   = S_ACCEPT;
          len_d     = (frame_len_in > MAX_LEN) ? MAX_LEN : frame_len_in;
          pix_d     = '0;
          bit_idx_d = '0;
          busy_d    = 1'b1;
`ifdef NEOPIXEL_BRIGHTNESS_EN
          bri_d     = brightness_in;
`endif
        end
      end
      S_ACCEPT: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? S_RST : S_FETCH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d    = load_word;
        bit_data_d = load_word[PIXEL_BITS-1];
        bit_rdy_d  = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (bit_done_in) begin
          if (bit_idx_q != LAST_BIT) begin
            shift_d    = shift_q << 1;
            bit_data_d = shift_q[PIXEL_BITS-2];
            bit_idx_d  = bit_idx_q + BW'(1);
            bit_rdy_d  = 1'b1;
          end else if ((pix_q + (ADDR_WIDTH + 1)'(1)) < len_q) begin
            pix_d     = pix_q + (ADDR_WIDTH + 1)'(1);
            bit_idx_d = '0;
            state_d   = S_FETCH;
          end else begin
            cnt_d      = '0;
            bit_data_d = 1'b0;
            state_d    = S_RST;
          end
        end
      end
      S_RST: begin
        if (cnt_q == LAST_CNT) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      pix_q      <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_rdy_q  <= 1'b0;
      bit_data_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef NEOPIXEL_BRIGHTNESS_EN
      bri_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pix_q      <= pix_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_rdy_q  <= bit_rdy_d;
      bit_data_q <= bit_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef NEOPIXEL_BRIGHTNESS_EN
      bri_q      <= bri_d;
`endif
    end
  end

  assign bit_rdy_out    = bit_rdy_q;
  assign bit_data_out   = bit_data_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_neopixel_frame_ctl.sv
// Self-checking bench for neopixel_frame_ctl: randomized pixel contents, frame lengths,
// brightness and handshake delays, compared against a bit-list reference model.
module tb_neopixel_frame_ctl;

  localparam int PB    = 24;
  localparam int AW    = 4;
  localparam int RC    = 37;
  localparam int LANES = PB / 8;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [LANES-1:0] byte_en = '0;
  logic [7:0]       byte_data = '0;
  logic             frame_rdy = 1'b0;
  logic [AW:0]      frame_len = '0;
  logic [7:0]       brightness = '0;
  logic             bit_done = 1'b0;
  logic             bit_rdy_out;
  logic             bit_data_out;
  logic             busy_out;
  logic             frame_done_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [PB-1:0] ref_mem [DEPTH];

  neopixel_frame_ctl #(
    .PIXEL_BITS  (PB),
    .ADDR_WIDTH  (AW),
    .RESET_CYCLES(RC)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .wr_en_in      (wr_en),
    .wr_addr_in    (wr_addr),
    .byte_en_in    (byte_en),
    .byte_data_in  (byte_data),
    .frame_rdy_in  (frame_rdy),
    .frame_len_in  (frame_len),
    .brightness_in (brightness),
    .bit_done_in   (bit_done),
    .bit_rdy_out   (bit_rdy_out),
    .bit_data_out  (bit_data_out),
    .busy_out      (busy_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: each byte scaled as floor(b*(bri+1)/256) when brightness is built in
  function automatic logic [PB-1:0] expect_word(input logic [PB-1:0] w, input int bri);
`ifdef NEOPIXEL_BRIGHTNESS_EN
    int unsigned r = 0;
    int unsigned b;
    for (int l = 0; l < LANES; l++) begin
      b = (int'(w) >> (8 * l)) & 255;
      r = r + (((b * (bri + 1)) / 256) << (8 * l));
    end
    return PB'(r);
`else
    return w;
`endif
  endfunction

  task automatic wr(input int addr, input logic [LANES-1:0] be, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(addr); byte_en = be; byte_data = d;
    for (int l = 0; l < LANES; l++) if (be[l]) ref_mem[addr][8*l +: 8] = d;
    @(negedge clk);
    wr_en = 1'b0; byte_en = '0;
  endtask

  task automatic wr_word(input int addr, input logic [PB-1:0] w);
    for (int l = 0; l < LANES; l++) wr(addr, LANES'(1) << l, w[8*l +: 8]);
  endtask

  // Runs one frame; abort_at>0 asserts reset right after that many bits were seen
  task automatic run_frame(input int len_req, input int bri, input bit disturb, input int abort_at);
    logic exp_bits[$];
    logic [PB-1:0] w;
    int eff_len, got, acc_edge, prev_done_edge, pending, exp_edge, budget;
    bit finished;
    eff_len = (len_req > DEPTH) ? DEPTH : len_req;
    for (int p = 0; p < eff_len; p++) begin
      w = expect_word(ref_mem[p], bri);
      for (int b = PB - 1; b >= 0; b--) exp_bits.push_back(w[b]);
    end
    @(negedge clk);
    frame_rdy = 1'b1; frame_len = (AW + 1)'(len_req); brightness = 8'(bri);
    @(negedge clk);
    frame_rdy = 1'b0;
    acc_edge = cyc;
    chk("busy_after_accept", busy_out, 1);
    got = 0; prev_done_edge = 0; pending = -1; finished = 0;
    budget = eff_len * PB * 6 + RC + 20;
    for (int t = 0; t < budget && !finished; t++) begin
      if (bit_rdy_out) begin
        if (got >= exp_bits.size()) chk("extra_bit", 1, 0);
        else chk("bit_data", bit_data_out, exp_bits[got]);
        if (got == 0) exp_edge = acc_edge + 3;
        else if (got % PB == 0) exp_edge = prev_done_edge + 2;
        else exp_edge = prev_done_edge;
        chk("bit_timing", cyc, exp_edge);
        chk("busy_in_frame", busy_out, 1);
        got++;
        if (got == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_bit_rdy", bit_rdy_out, 0);
          chk("rst_bit_data", bit_data_out, 0);
          chk("rst_busy", busy_out, 0);
          chk("rst_frame_done", frame_done_out, 0);
          return;
        end
        pending = $urandom_range(0, 2);
      end
      if (frame_done_out) begin
        exp_edge = (eff_len == 0) ? acc_edge + 1 + RC : prev_done_edge + RC;
        chk("done_timing", cyc, exp_edge);
        chk("busy_at_done", busy_out, 0);
        chk("data_at_done", bit_data_out, 0);
        chk("bit_count", got, exp_bits.size());
        finished = 1;
      end else begin
        if (pending == 0) begin
          bit_done = 1'b1;
          prev_done_edge = cyc + 1;
          pending = -1;
        end else if (pending > 0) begin
          pending--;
        end
        if (disturb && $urandom_range(0, 7) == 0) begin
          frame_rdy = 1'b1;
          frame_len = (AW + 1)'($urandom);
        end
        @(negedge clk);
        bit_done = 1'b0;
        frame_rdy = 1'b0;
      end
    end
    chk("frame_completed", finished, 1);
    @(negedge clk);
    chk("done_is_pulse", frame_done_out, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_bit_rdy", bit_rdy_out, 0);
    chk("reset_bit_data", bit_data_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_frame_done", frame_done_out, 0);
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) wr_word(a, PB'($urandom));

    // bit_done in IDLE must not produce bits or start anything
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bit_done = 1'b1;
      @(negedge clk);
      bit_done = 1'b0;
      chk("idle_no_bit", bit_rdy_out, 0);
      chk("idle_not_busy", busy_out, 0);
    end

    wr_word(0, 24'hA5C30F);
    run_frame(1, 255, 0, -1);

    wr_word(0, 24'hFFFFFF);
    wr_word(1, 24'h000000);
    wr_word(2, 24'h800001);
    run_frame(3, 255, 0, -1);

    run_frame(0, 255, 0, -1);

    wr_word(0, 24'hFF8001);
    run_frame(1, 127, 0, -1);
    run_frame(2, 0, 0, -1);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++)
        wr($urandom_range(0, DEPTH - 1), LANES'($urandom), 8'($urandom));
      run_frame($urandom_range(1, DEPTH), $urandom_range(0, 255), 1, -1);
    end

    run_frame(DEPTH + 4, $urandom_range(0, 255), 1, -1);

    run_frame(4, 255, 0, PB + (PB - 1 - 5) + 1);
    bit_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < RC + 5; i++) begin
      @(negedge clk);
      if (frame_done_out || busy_out || bit_rdy_out) chk("no_activity_after_reset", 1, 0);
    end
    chk("idle_after_reset", busy_out, 0);
    run_frame(4, 255, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
